// File: rtl/pwm_multi.sv
// ---------------------------------------------------------------------------
// pwm_multi: multi-channel PWM generator with one shared period counter and
// double-buffered per-channel duty values.
//
// A load strobe captures duty_in into a shadow bank. The shadow bank is copied
// into the active bank only at a period wrap, so a channel never sees a
// partially updated period. The counter advances on the 1 MHz tick_enable
// pulse from the divider. Every channel output and status flag is registered.
//
// Optional build macro:
//   PWM_PHASE_STAGGER_EN  When defined, channel k compares against
//                         (cnt + k*(PERIOD/NUM_CH)) mod PERIOD instead of cnt.
//                         This spreads the rising edges of the channels across
//                         the period.
//
// Parameters:
//   NUM_CH  number of channels (1..8)
//   DUTY_W  duty field width; 2^DUTY_W-1 must be >= PERIOD
//   PERIOD  ticks per PWM period (2..2^DUTY_W-1)
//   CNT_W   counter width, derived from PERIOD as a localparam
//
// Ports:
//   clk           system clock (25 MHz)
//   reset         synchronous, active-high reset
//   tick_enable   one-clk pulse per tick
//   duty_in       packed duties; channel k is at [k*DUTY_W +: DUTY_W]
//   load          one-clk strobe; captures duty_in into the shadow bank
//   out           registered PWM outputs, one bit per channel
//   period_start  one-clk pulse on the edge where the counter wraps to 0
//   pending       high while the shadow bank holds duties not yet applied
// ---------------------------------------------------------------------------
module pwm_multi #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DUTY_W = 7,
  parameter int unsigned PERIOD = 100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick_enable,
  input  logic [NUM_CH*DUTY_W-1:0] duty_in,
  input  logic                     load,
  output logic [NUM_CH-1:0]        out,
  output logic                     period_start,
  output logic                     pending
);

  localparam int unsigned CNT_W = $clog2(PERIOD);

  logic [CNT_W-1:0]              cnt;
  logic [NUM_CH-1:0][DUTY_W-1:0] shadow;
  logic [NUM_CH-1:0][DUTY_W-1:0] active;
  logic                          wrap_c;
  logic [NUM_CH-1:0]             out_nxt_c;

  // The counter wraps on the tick that would otherwise take it to PERIOD.
  assign wrap_c = tick_enable && (cnt == CNT_W'(PERIOD - 1));

`ifdef PWM_PHASE_STAGGER_EN
  localparam int unsigned PH_STEP = PERIOD / NUM_CH;

  // Per-channel phase. cnt + offset is always below 2*PERIOD because the
  // offset is below PERIOD, so a single conditional subtract gives the modulo.
  always_comb begin
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] phase;
    out_nxt_c = '0;
    sum       = '0;
    phase     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum   = (CNT_W + 1)'(cnt) + (CNT_W + 1)'(k * PH_STEP);
      phase = (sum >= (CNT_W + 1)'(PERIOD)) ? CNT_W'(sum - (CNT_W + 1)'(PERIOD))
                                             : CNT_W'(sum);
      out_nxt_c[k] = DUTY_W'(phase) < active[k];
    end
  end
`else
  // All channels share cnt, so rising edges coincide at cnt == 0.
  always_comb begin
    out_nxt_c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      out_nxt_c[k] = DUTY_W'(cnt) < active[k];
    end
  end
`endif

  // Counter, shadow/active banks, pending flag and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      shadow       <= '0;
      active       <= '0;
      pending      <= 1'b0;
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      if (tick_enable) begin
        cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
      end

      period_start <= wrap_c;

      // The wrap applies the shadow contents held before this edge, so a load
      // in the same cycle lands in the shadow bank for the following wrap.
      if (wrap_c && pending) begin
        active <= shadow;
      end

      if (load) begin
        shadow  <= duty_in;
        pending <= 1'b1;
      end else if (wrap_c) begin
        pending <= 1'b0;
      end

      out <= out_nxt_c;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi: scoreboard bench for pwm_multi. The stimulus process drives
// inputs and pushes the response predicted by a tick-level reference model.
// A monitor process pops one prediction per clock and compares it with the
// DUT. Directed scenarios add bench-side measurements of high time, wrap
// spacing and rising-edge lag.
// ---------------------------------------------------------------------------
module tb_pwm_multi;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DUTY_W = 7;
  localparam int unsigned PERIOD = 100;
  localparam int unsigned DW     = NUM_CH * DUTY_W;
`ifdef PWM_PHASE_STAGGER_EN
  localparam int          LAG    = 50;
`else
  localparam int          LAG    = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              tick_enable;
  logic              load;
  logic [DW-1:0]     duty_in;
  logic [NUM_CH-1:0] out;
  logic              period_start;
  logic              pending;

  pwm_multi #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .PERIOD(PERIOD)) dut (
    .clk(clk), .reset(reset), .tick_enable(tick_enable), .duty_in(duty_in),
    .load(load), .out(out), .period_start(period_start), .pending(pending)
  );

  always #20 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] out;
    logic              ps;
    logic              pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   gclk  = 0;
  int   div   = 1;

  // Reference model state: tick position within the period plus the duty banks.
  int   m_cnt;
  int   m_act[NUM_CH];
  int   m_sh[NUM_CH];
  bit   m_pend;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (clk %0d)", name, act, req, gclk);
    end
  endtask

  // Predicts the outputs after the next edge and advances the model.
  function automatic exp_t model(input bit rst, input bit te, input bit ld,
                                 input logic [DW-1:0] d);
    exp_t e;
    bit   wrap;
    int   ph;
    e = '0;
    if (rst) begin
      m_cnt  = 0;
      m_pend = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_act[k] = 0;
        m_sh[k]  = 0;
      end
      return e;
    end
    wrap = te && (m_cnt == PERIOD - 1);
    for (int k = 0; k < NUM_CH; k++) begin
`ifdef PWM_PHASE_STAGGER_EN
      ph = (m_cnt + k * (PERIOD / NUM_CH)) % PERIOD;
`else
      ph = m_cnt;
`endif
      e.out[k] = (ph < m_act[k]);
    end
    e.ps = wrap;
    if (wrap && m_pend)
      for (int k = 0; k < NUM_CH; k++) m_act[k] = m_sh[k];
    if (ld) begin
      for (int k = 0; k < NUM_CH; k++) m_sh[k] = int'(d[k*DUTY_W +: DUTY_W]);
      m_pend = 1;
    end else if (wrap) begin
      m_pend = 0;
    end
    e.pend = m_pend;
    if (te) m_cnt = wrap ? 0 : m_cnt + 1;
    return e;
  endfunction

  // Monitor: the DUT presents a new output set every clock.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out", int'(out), int'(e.out));
      check("period_start", int'(period_start), int'(e.ps));
      check("pending", int'(pending), int'(e.pend));
    end
  end

  task automatic step(input bit rst, input bit te, input bit ld,
                      input logic [DW-1:0] d);
    exp_t e;
    reset       = rst;
    tick_enable = te;
    load        = ld;
    duty_in     = d;
    e = model(rst, te, ld, d);
    @(posedge clk);
    exp_q.push_back(e);
    gclk++;
    #1;
  endtask

  // One clock with tick_enable pulsed every 'div' clocks.
  task automatic tstep(input bit ld, input logic [DW-1:0] d);
    step(1'b0, (gclk % div) == 0, ld, d);
  endtask

  function automatic logic [DW-1:0] pack2(input int d1, input int d0);
    logic [DW-1:0] r;
    r = '0;
    r[0 +: DUTY_W]      = DUTY_W'(d0);
    r[DUTY_W +: DUTY_W] = DUTY_W'(d1);
    return r;
  endfunction

  task automatic wait_ps(input int budget);
    int n;
    n = 0;
    do begin
      tstep(1'b0, '0);
      n++;
    end while (!period_start && n < budget);
    check("period_start_seen", int'(period_start), 1);
  endtask

  task automatic count_high(input int n, output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    for (int i = 0; i < n; i++) begin
      tstep(1'b0, '0);
      h0 += int'(out[0]);
      h1 += int'(out[1]);
    end
  endtask

  task automatic wait_model_cnt(input int target);
    int n;
    n = 0;
    while (m_cnt != target && n < 3 * PERIOD) begin
      tstep(1'b0, '0);
      n++;
    end
    check("model_cnt_reached", m_cnt, target);
  endtask

  function automatic int rnd_duty();
    case ($urandom % 6)
      0:       return 0;
      1:       return 1;
      2:       return PERIOD - 1;
      3:       return PERIOD;
      4:       return (1 << DUTY_W) - 1;
      default: return int'($urandom % (1 << DUTY_W));
    endcase
  endfunction

  initial begin
    int t, h0, h1, t0, t1;
    bit p0, p1;
    reset = 1'b1; tick_enable = 1'b0; load = 1'b0; duty_in = '0;

    // Reset, then idle at 1 tick per 25 clks: outputs low, wraps 2500 clks apart.
    div = 25;
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    check("reset_out", int'(out), 0);
    wait_ps(3000);
    t = gclk;
    wait_ps(3000);
    check("ps_interval", gclk - t, int'(PERIOD) * 25);
    check("idle_out", int'(out), 0);

    // Mid-period load {ch1=30, ch0=75}; applied at the next wrap.
    count_high(1000, h0, h1);
    tstep(1'b1, pack2(30, 75));
    check("pending_after_load", int'(pending), 1);
    wait_ps(3000);
    check("pending_at_wrap", int'(pending), 0);
    count_high(int'(PERIOD) * 25, h0, h1);
    check("high_ch0_75", h0, 75 * 25);
    check("high_ch1_30", h1, 30 * 25);

    // Load coincident with a wrap: pending 10 applies now, 40 at the next wrap.
    div = 1;
    tstep(1'b1, pack2(0, 10));
    wait_model_cnt(int'(PERIOD) - 1);
    tstep(1'b1, pack2(0, 40));
    check("wrap_load_ps", int'(period_start), 1);
    check("wrap_load_pending", int'(pending), 1);
    count_high(int'(PERIOD), h0, h1);
    check("high_ch0_10", h0, 10);
    wait_ps(300);
    count_high(int'(PERIOD), h0, h1);
    check("high_ch0_40", h0, 40);

    // Boundary duties: 0 stays low, 100 and 127 stay high across wraps.
    div = 5;
    tstep(1'b1, pack2(int'(PERIOD), 0));
    wait_ps(1000);
    count_high(3 * int'(PERIOD) * 5, h0, h1);
    check("duty0_high", h0, 0);
    check("duty100_high", h1, 3 * int'(PERIOD) * 5);
    tstep(1'b1, pack2((1 << DUTY_W) - 1, 0));
    wait_ps(1000);
    count_high(3 * int'(PERIOD) * 5, h0, h1);
    check("duty127_high", h1, 3 * int'(PERIOD) * 5);

    // Reset at cnt=50 while out[0] is high; outputs stay low afterwards.
    div = 1;
    tstep(1'b1, pack2(0, 75));
    wait_ps(300);
    wait_model_cnt(50);
    check("pre_reset_out0", int'(out[0]), 1);
    step(1'b1, 1'b1, 1'b1, pack2(20, 20));
    check("reset_mid_out", int'(out), 0);
    check("reset_mid_pending", int'(pending), 0);
    count_high(3 * int'(PERIOD), h0, h1);
    check("post_reset_ch0", h0, 0);
    check("post_reset_ch1", h1, 0);

    // Rising-edge lag between channels at duty 50.
    tstep(1'b1, pack2(50, 50));
    wait_ps(300);
    t0 = -1; t1 = -1;
    for (int i = 0; i < 3 * int'(PERIOD) && t1 < 0; i++) begin
      p0 = out[0];
      p1 = out[1];
      tstep(1'b0, '0);
      if (t0 < 0 && !p0 && out[0]) t0 = gclk;
      if (t0 >= 0 && !p1 && out[1]) t1 = gclk;
    end
    check("rise1_found", int'(t1 >= 0), 1);
    check("rise_lag", t1 - t0, LAG);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 6000; i++) begin
      if (i % 1500 == 0) div = 1 + int'($urandom % 4);
      if ($urandom % 400 == 0)
        step(1'b1, $urandom % 2 == 0, $urandom % 2 == 0, pack2(rnd_duty(), rnd_duty()));
      else
        tstep($urandom % 50 == 0, pack2(rnd_duty(), rnd_duty()));
    end

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
